// File: rtl/matmul_job_sequencer.sv
// Job sequencer for the i4 x i8 MAC array: loads weights/activations from a byte stream,
// steps K_LEN accumulate cycles, then drains each slice's accumulator. Option: WEIGHT_REUSE_EN.
module matmul_job_sequencer #(
  parameter int unsigned COMPUTE_SLICES = 4,
  parameter int unsigned K_LEN          = 8,
  parameter int unsigned ACC_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef WEIGHT_REUSE_EN
  input  logic reuse_w,
`endif
  input  logic in_valid,
  output logic in_ready,
  output logic w_we,
  output logic [((COMPUTE_SLICES*K_LEN/2) > 1 ? $clog2(COMPUTE_SLICES*K_LEN/2) : 1)-1:0] w_addr,
  output logic a_we,
  output logic [$clog2(K_LEN)-1:0] a_addr,
  output logic acc_en,
  output logic acc_clr,
  output logic [$clog2(K_LEN)-1:0] k_idx,
  output logic out_valid,
  input  logic out_ready,
  output logic [(COMPUTE_SLICES > 1 ? $clog2(COMPUTE_SLICES) : 1)-1:0] out_sel,
  output logic byte_sel,
  output logic busy,
  output logic done
);

  localparam int unsigned WBytes     = COMPUTE_SLICES * K_LEN / 2;
  localparam int unsigned WAddrW     = (WBytes > 1) ? $clog2(WBytes) : 1;
  localparam int unsigned KW         = $clog2(K_LEN);
  localparam int unsigned SelW       = (COMPUTE_SLICES > 1) ? $clog2(COMPUTE_SLICES) : 1;
  localparam int unsigned DrainBytes = COMPUTE_SLICES * (ACC_W / 8);
  localparam int unsigned MaxA       = (WBytes > K_LEN) ? WBytes : K_LEN;
  localparam int unsigned MaxCnt     = (MaxA > DrainBytes) ? MaxA : DrainBytes;
  localparam int unsigned CntW       = $clog2(MaxCnt) + 1;

  typedef enum logic [2:0] {StIdle, StLoadW, StLoadA, StCompute, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              skip_w;
  logic              w_load_last;

  // One counter serves every phase; it is cleared on each phase transition.
  assign w_load_last = (state_q == StLoadW) && in_valid && (cnt_q == CntW'(WBytes - 1));

`ifdef WEIGHT_REUSE_EN
  logic w_loaded_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_loaded_q <= 1'b0;
    end else if (w_load_last) begin
      w_loaded_q <= 1'b1;
    end
  end

  assign skip_w = reuse_w & w_loaded_q;
`else
  assign skip_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = '0;
          state_d = skip_w ? StLoadA : StLoadW;
        end
      end
      StLoadW: begin
        if (in_valid) begin
          if (w_load_last) begin
            cnt_d   = '0;
            state_d = StLoadA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StLoadA: begin
        if (in_valid) begin
          if (cnt_q == CntW'(K_LEN - 1)) begin
            cnt_d   = '0;
            state_d = StCompute;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCompute: begin
        if (cnt_q == CntW'(K_LEN - 1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (cnt_q == CntW'(DrainBytes - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Addresses are masked outside their phase so idle outputs stay at zero.
  always_comb begin
    in_ready  = (state_q == StLoadW) || (state_q == StLoadA);
    w_we      = (state_q == StLoadW) && in_valid;
    a_we      = (state_q == StLoadA) && in_valid;
    w_addr    = (state_q == StLoadW) ? cnt_q[WAddrW-1:0] : '0;
    a_addr    = (state_q == StLoadA) ? cnt_q[KW-1:0] : '0;
    acc_en    = (state_q == StCompute);
    acc_clr   = (state_q == StCompute) && (cnt_q == '0);
    k_idx     = (state_q == StCompute) ? cnt_q[KW-1:0] : '0;
    out_valid = (state_q == StDrain);
    out_sel   = (state_q == StDrain) ? cnt_q[SelW:1] : '0;
    byte_sel  = (state_q == StDrain) && cnt_q[0];
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Randomized bench for matmul_job_sequencer against a job-progress reference model.
module tb_matmul_job_sequencer;

  localparam int S  = 4;
  localparam int K  = 8;
  localparam int WB = S * K / 2;
  localparam int DB = 2 * S;

`ifdef WEIGHT_REUSE_EN
  localparam bit ReuseFeature = 1'b1;
`else
  localparam bit ReuseFeature = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       reuse_w = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, w_we, a_we, acc_en, acc_clr, out_valid, byte_sel, busy, done;
  logic [3:0] w_addr;
  logic [2:0] a_addr, k_idx;
  logic [1:0] out_sel;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Reference model: progress of the job measured in bytes accepted, compute beats and
  // drained bytes; the phase is derived from those totals.
  bit m_active = 1'b0;
  bit m_wloaded = 1'b0;
  int m_cons = 0;
  int m_comp = 0;
  int m_drn = 0;

  matmul_job_sequencer #(.COMPUTE_SLICES(S), .K_LEN(K), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef WEIGHT_REUSE_EN
    .reuse_w   (reuse_w),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .k_idx     (k_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .byte_sel  (byte_sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phase();
    if (!m_active) return 0;
    if (m_cons < WB) return 1;
    if (m_cons < WB + K) return 2;
    if (m_comp < K) return 3;
    if (m_drn < DB) return 4;
    return 5;
  endfunction

  function automatic logic [31:0] dut_outs();
    return {11'd0, busy, done, in_ready, w_we, a_we, acc_en, acc_clr, out_valid, byte_sel,
            w_addr, a_addr, k_idx, out_sel};
  endfunction

  function automatic logic [31:0] model_outs();
    int ph = phase();
    logic [3:0] wa = '0;
    logic [2:0] aa = '0;
    logic [2:0] ki = '0;
    logic [1:0] os = '0;
    logic bs = 1'b0;
    if (ph == 1) wa = 4'(m_cons);
    if (ph == 2) aa = 3'(m_cons - WB);
    if (ph == 3) ki = 3'(m_comp);
    if (ph == 4) begin
      os = 2'(m_drn / 2);
      bs = (m_drn % 2) == 1;
    end
    return {11'd0, ph != 0, ph == 5, (ph == 1) || (ph == 2), (ph == 1) && in_valid,
            (ph == 2) && in_valid, ph == 3, (ph == 3) && (m_comp == 0), ph == 4, bs,
            wa, aa, ki, os};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_wloaded = 1'b0;
    m_cons = 0;
    m_comp = 0;
    m_drn = 0;
  endtask

  task automatic model_clock();
    case (phase())
      0: if (start) begin
        m_active = 1'b1;
        m_cons = (ReuseFeature && reuse_w && m_wloaded) ? WB : 0;
        m_comp = 0;
        m_drn = 0;
      end
      1: if (in_valid) begin
        m_cons++;
        if (m_cons == WB) m_wloaded = 1'b1;
      end
      2: if (in_valid) m_cons++;
      3: m_comp++;
      4: if (out_ready) m_drn++;
      default: m_active = 1'b0;
    endcase
  endtask

  task automatic step(input bit st, input bit iv, input bit ordy, input bit ru);
    @(negedge clk);
    start = st;
    in_valid = iv;
    out_ready = ordy;
    reuse_w = ru;
    #1;
    check("outs", dut_outs(), model_outs());
    if (done) done_seen++;
    @(posedge clk);
    if (rst) model_reset();
    else model_clock();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", dut_outs(), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: no bubbles; mode 1: random in_valid/out_ready and stray start pulses.
  task automatic run_job(input int mode, input bit ru);
    int n = 0;
    done_seen = 0;
    step(1'b1, (mode == 1) ? 1'($urandom % 2) : 1'b1, 1'b1, ru);
    while (m_active && n < 600) begin
      if (mode == 1) step(($urandom % 6) == 0, 1'($urandom % 2), ($urandom % 3) != 0, 1'b0);
      else step(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    check("job_timeout", 32'(m_active), 32'd0);
    check("done_pulses", 32'(done_seen), 32'd1);
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // Clean job: exercises the exact cycle-by-cycle latency.
    run_job(0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom % 2), 1'b1, 1'b0);
      run_job(1, 1'b0);
    end

    // Reset in the middle of activation loading, then a full job again.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 100 && m_cons < WB + 3; n++) step(1'b0, 1'b1, 1'b1, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run_job(0, 1'b0);

    // Weight reuse: skipped LOAD_W only when weights were loaded since reset.
    run_job(0, 1'b1);
    run_job(1, 1'b1);
    do_reset();
    run_job(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_job_sequencer.md
Name: matmul_job_sequencer

Overview:
Control sequencer for the i4×i8 multiply-accumulate array (COMPUTE_SLICES parallel slices). It accepts one byte stream over a valid/ready handshake and splits it into packed i4 weights and i8 activations, with write strobes and addresses into datapath storage. It then steps all slices through K_LEN accumulate cycles and drains each slice's accumulator as bytes over a second valid/ready handshake. It sits between the 8-bit pin interface and the compute slices.

Parameters:
COMPUTE_SLICES, 4, number of parallel MAC slices; ≥1.
K_LEN, 8, dot-product length per slice; even, ≥2.
ACC_W, 16, accumulator width in bits; fixed at 16 (drained as 2 bytes).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin job; sampled only in IDLE
in_valid  in  1  input byte valid
in_ready  out  1  sequencer accepts input byte
w_we  out  1  weight byte write strobe (two packed i4, low nibble = even k)
w_addr  out  clog2(COMPUTE_SLICES*K_LEN/2)  weight byte address
a_we  out  1  activation byte write strobe
a_addr  out  clog2(K_LEN)  activation address
acc_en  out  1  all slices accumulate product at k_idx
acc_clr  out  1  with acc_en: load product instead of adding
k_idx  out  clog2(K_LEN)  current dot-product index
out_valid  out  1  drain byte valid
out_ready  in  1  drain byte accepted
out_sel  out  clog2(COMPUTE_SLICES)  slice being drained
byte_sel  out  1  0 = acc[7:0], 1 = acc[15:8]
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE; all counters 0; every output 0. Applies immediately, including mid-job. No partial job resumes.
- W_BYTES = COMPUTE_SLICES*K_LEN/2. Bytes are ordered slice-major: slice s occupies addresses s*K_LEN/2 .. s*K_LEN/2+K_LEN/2-1.
- IDLE: in_ready=0. start=1 → LOAD_W next cycle. A byte presented with in_valid in the same cycle as start is not consumed.
- LOAD_W: in_ready=1. On each in_valid&in_ready: w_we=1 (combinational with the handshake), w_addr = current count, then count+1. On the W_BYTES-th handshake → LOAD_A, count reset.
- LOAD_A: same as LOAD_W using a_we/a_addr. On the K_LEN-th handshake → COMPUTE.
- COMPUTE: in_ready=0; acc_en=1 for exactly K_LEN consecutive cycles, k_idx=0..K_LEN-1; acc_clr=1 only when k_idx=0. After k_idx=K_LEN-1 → DRAIN.
- DRAIN: out_valid=1. Order is (slice 0, byte 0), (slice 0, byte 1), (slice 1, byte 0) … through slice COMPUTE_SLICES-1. out_sel and byte_sel advance only on out_valid&out_ready and hold stable under backpressure. The final handshake → DONE.
- DONE: done=1 and busy=1 for one cycle, out_valid=0 → IDLE.
- start outside IDLE is ignored. in_valid outside LOAD_* is ignored.
- Gaps in in_valid stall the counters; no timeout.
- Latency with no bubbles, start asserted in cycle 0: first w_we in cycle 1; first a_we in cycle 1+W_BYTES; first acc_en in cycle 1+W_BYTES+K_LEN; first out_valid in cycle 1+W_BYTES+2*K_LEN.

Optional Feature:
WEIGHT_REUSE_EN:
- When defined: adds input reuse_w (1 bit), sampled with start, plus an internal w_loaded flag. w_loaded is set at LOAD_W completion and cleared by rst.
- start&reuse_w&w_loaded → LOAD_A directly, skipping LOAD_W.
- reuse_w with w_loaded=0 behaves as reuse_w=0.
- When undefined: port absent and LOAD_W always runs.

Test Plan:
Defaults (COMPUTE_SLICES=4, K_LEN=8, W_BYTES=16) unless noted.
1. Assert rst mid-cycle → all outputs 0 asynchronously; after release, busy=0 and in_ready=0.
2. start in cycle 0, in_valid held 1, out_ready held 1:
   - w_we cycles 1–16, w_addr 0..15.
   - a_we cycles 17–24, a_addr 0..7.
   - acc_en cycles 25–32, acc_clr only in cycle 25.
   - out_valid cycles 33–40, (out_sel,byte_sel) = (0,0),(0,1),(1,0)…(3,1).
   - done in cycle 41 → IDLE.
3. in_valid toggling every other cycle, out_ready low for 3 cycles at byte (2,1) → addresses advance only on handshakes; out_sel=2/byte_sel=1 held stable; still exactly 16 w_we and 8 out handshakes.
4. start pulsed during LOAD_A and during DRAIN → no effect; job completes with identical strobe sequence and a single done.
5. rst asserted after 3 a_we → immediate IDLE. A new start gives w_addr 0 on the first w_we, and the full 16-byte weight load is repeated.
6. WEIGHT_REUSE_EN defined:
   - Complete one job, then start&reuse_w=1 → first handshake is a_we with a_addr=0 one cycle after start; no w_we.
   - After rst, start&reuse_w=1 → LOAD_W runs.
